// File: rtl/scl_spare_eco_bank.sv
// Reconfigurable bank of spare logic cells for metal-ECO repair.
// Cell functions come from a serially loaded shadow chain committed to an active copy.
module scl_spare_eco_bank #(
  parameter int unsigned NUM_CELLS = 4,
  parameter int unsigned CFG_W     = 3
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cfg_sdi,
  input  logic                 cfg_shift_en,
  input  logic                 cfg_commit,
  input  logic                 cfg_err_clr,
  input  logic [NUM_CELLS-1:0] cell_a,
  input  logic [NUM_CELLS-1:0] cell_b,
  output logic [NUM_CELLS-1:0] cell_y,
  output logic                 cfg_sdo,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 lo
);

  localparam int unsigned TOT_BITS = NUM_CELLS * CFG_W;
  localparam int unsigned CNT_W    = $clog2(TOT_BITS + 2);
  localparam int unsigned CNT_FULL = TOT_BITS;
  localparam int unsigned CNT_SAT  = TOT_BITS + 1;

  typedef enum logic [2:0] {
    M_TIE_LO = 3'd0,
    M_TIE_HI = 3'd1,
    M_INV    = 3'd2,
    M_NAND   = 3'd3,
    M_NOR    = 3'd4,
    M_BUF    = 3'd5,
    M_DFF    = 3'd6,
    M_TOGGLE = 3'd7
  } cell_mode_e;

  logic [TOT_BITS-1:0]  shadow_q, shadow_d;
  logic [TOT_BITS-1:0]  active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CELLS-1:0] state_q, state_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 commit_req;
  logic                 commit_ok;

  // Commit is only honoured on a cycle without a shift.
  assign commit_req = cfg_commit & ~cfg_shift_en;
  assign commit_ok  = commit_req && (cnt_q == CNT_W'(CNT_FULL));

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (cfg_shift_en) begin
      shadow_d = {shadow_q[TOT_BITS-2:0], cfg_sdi};
      if (cnt_q < CNT_W'(CNT_SAT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (cfg_err_clr) begin
      err_d = 1'b0;
    end

    if (commit_ok) begin
      active_d = shadow_q;
      cnt_d    = '0;
      done_d   = 1'b1;
    end else if (commit_req) begin
      cnt_d = '0;
      err_d = 1'b1;
    end
  end

  // Per-cell state flop: cleared when a commit changes that cell's mode.
  always_comb begin
    state_d = state_q;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (commit_ok &&
          (active_d[k*CFG_W +: CFG_W] != active_q[k*CFG_W +: CFG_W])) begin
        state_d[k] = 1'b0;
      end else begin
        case (cell_mode_e'(active_q[k*CFG_W +: CFG_W]))
          M_DFF:    state_d[k] = cell_a[k];
          M_TOGGLE: state_d[k] = cell_a[k] ? ~state_q[k] : state_q[k];
          default:  state_d[k] = state_q[k];
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Cell function decode; depends only on flopped config, so no config glitches.
  always_comb begin
    cell_y = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      case (cell_mode_e'(active_q[k*CFG_W +: CFG_W]))
        M_TIE_LO: cell_y[k] = 1'b0;
        M_TIE_HI: cell_y[k] = 1'b1;
        M_INV:    cell_y[k] = ~cell_a[k];
        M_NAND:   cell_y[k] = ~(cell_a[k] & cell_b[k]);
        M_NOR:    cell_y[k] = ~(cell_a[k] | cell_b[k]);
        M_BUF:    cell_y[k] = cell_a[k];
        M_DFF:    cell_y[k] = state_q[k];
        M_TOGGLE: cell_y[k] = state_q[k];
        default:  cell_y[k] = 1'b0;
      endcase
    end
  end

  assign cfg_sdo  = shadow_q[TOT_BITS-1];
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign lo       = 1'b0;

endmodule

// File: tb/tb_scl_spare_eco_bank.sv
// Directed bench for scl_spare_eco_bank: config load/commit, cell modes, errors, chaining.
module tb_scl_spare_eco_bank;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b0;
  logic       cfg_sdi = 1'b0;
  logic       cfg_shift_en = 1'b0;
  logic       cfg_commit = 1'b0;
  logic       cfg_err_clr = 1'b0;
  logic [3:0] cell_a = 4'h0;
  logic [3:0] cell_b = 4'h0;
  logic [3:0] cell_y;
  logic       cfg_sdo;
  logic       cfg_done;
  logic       cfg_err;
  logic       lo;

  int n_checks = 0;
  int n_errors = 0;

  scl_spare_eco_bank #(.NUM_CELLS(4), .CFG_W(3)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cfg_sdi      (cfg_sdi),
    .cfg_shift_en (cfg_shift_en),
    .cfg_commit   (cfg_commit),
    .cfg_err_clr  (cfg_err_clr),
    .cell_a       (cell_a),
    .cell_b       (cell_b),
    .cell_y       (cell_y),
    .cfg_sdo      (cfg_sdo),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .lo           (lo)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_sdi      = v[i];
      cfg_shift_en = 1'b1;
      tick();
    end
    cfg_shift_en = 1'b0;
    cfg_sdi      = 1'b0;
  endtask

  task automatic pulse_commit;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset;
    cell_a = 4'hF;
    #2 wb_rst_i = 1'b1;
    #1;
    n_checks++;
    if (cell_y !== 4'h0) begin n_errors++; $display("FAIL reset_y got %h exp 0", cell_y); end
    n_checks++;
    if ({cfg_sdo, cfg_err, cfg_done} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b exp 000", {cfg_sdo, cfg_err, cfg_done});
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    // Assert reset again in the middle of a shift sequence.
    cfg_sdi = 1'b1;
    cfg_shift_en = 1'b1;
    tick();
    tick();
    #2 wb_rst_i = 1'b1;
    #1;
    n_checks++;
    if ({cell_y, cfg_sdo, cfg_err, cfg_done} !== 7'b0) begin
      n_errors++; $display("FAIL reset_mid_shift got %b exp 0", {cell_y, cfg_sdo, cfg_err, cfg_done});
    end
    n_checks++;
    if (lo !== 1'b0) begin n_errors++; $display("FAIL lo_reset got %b exp 0", lo); end
    cfg_shift_en = 1'b0;
    cfg_sdi = 1'b0;
    cell_a = 4'h0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_full_load;
    cell_b = 4'hF;
    shift_bits(16'b1111_1001_1010, 12);
    n_checks++;
    if (cfg_done !== 1'b0) begin n_errors++; $display("FAIL done_before_commit got %b exp 0", cfg_done); end
    pulse_commit();
    n_checks++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL commit_ok got done=%b err=%b exp 1 0", cfg_done, cfg_err);
    end
    tick();
    n_checks++;
    if (cfg_done !== 1'b0) begin n_errors++; $display("FAIL done_pulse_len got %b exp 0", cfg_done); end
    cell_a = 4'b0101;
    #1;
    n_checks++;
    if (cell_y[1:0] !== 2'b10) begin n_errors++; $display("FAIL inv_nand_0101 got %b exp 10", cell_y[1:0]); end
    cell_a = 4'b0011;
    #1;
    n_checks++;
    if (cell_y[1:0] !== 2'b00) begin n_errors++; $display("FAIL inv_nand_0011 got %b exp 00", cell_y[1:0]); end
    cell_a = 4'b0000;
    #1;
    n_checks++;
    if (cell_y !== 4'b0011) begin n_errors++; $display("FAIL idle_y got %b exp 0011", cell_y); end
    tick();
  endtask

  task automatic test_sequential;
    cell_a = 4'b0100;
    #1;
    n_checks++;
    if (cell_y[2] !== 1'b0) begin n_errors++; $display("FAIL dff_latency got %b exp 0", cell_y[2]); end
    tick();
    n_checks++;
    if (cell_y[2] !== 1'b1) begin n_errors++; $display("FAIL dff_capture got %b exp 1", cell_y[2]); end
    cell_a = 4'b1000;
    tick();
    n_checks++;
    if (cell_y[3:2] !== 2'b10) begin n_errors++; $display("FAIL toggle_1 got %b exp 10", cell_y[3:2]); end
    tick();
    n_checks++;
    if (cell_y[3] !== 1'b0) begin n_errors++; $display("FAIL toggle_2 got %b exp 0", cell_y[3]); end
    tick();
    n_checks++;
    if (cell_y[3] !== 1'b1) begin n_errors++; $display("FAIL toggle_3 got %b exp 1", cell_y[3]); end
    cell_a = 4'b0000;
    tick();
    n_checks++;
    if (cell_y !== 4'b1011) begin n_errors++; $display("FAIL toggle_hold got %b exp 1011", cell_y); end
  endtask

  task automatic test_undershift;
    shift_bits(16'h0000, 11);
    pulse_commit();
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      n_errors++; $display("FAIL undershift got err=%b done=%b exp 1 0", cfg_err, cfg_done);
    end
    n_checks++;
    if (cell_y !== 4'b1011) begin n_errors++; $display("FAIL undershift_y got %b exp 1011", cell_y); end
    cfg_err_clr = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    cfg_commit = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      n_errors++; $display("FAIL clr_vs_set got err=%b done=%b exp 1 0", cfg_err, cfg_done);
    end
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL err_clear got %b exp 0", cfg_err); end
  endtask

  task automatic test_overshift_collision;
    shift_bits(16'h0000, 13);
    pulse_commit();
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
      n_errors++; $display("FAIL overshift got err=%b done=%b exp 1 0", cfg_err, cfg_done);
    end
    cfg_err_clr = 1'b1;
    tick();
    cfg_err_clr = 1'b0;
    shift_bits(16'h0000, 11);
    cfg_sdi = 1'b1;
    cfg_shift_en = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_sdi = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_commit = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin
      n_errors++; $display("FAIL collision got err=%b done=%b exp 0 0", cfg_err, cfg_done);
    end
    pulse_commit();
    n_checks++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_errors++; $display("FAIL commit_after_collision got done=%b err=%b exp 1 0", cfg_done, cfg_err);
    end
    n_checks++;
    if (cell_y !== 4'b0001) begin n_errors++; $display("FAIL tie_hi_y got %b exp 0001", cell_y); end
    tick();
  endtask

  task automatic test_chaining;
    logic [3:0] exp_sdo;
    exp_sdo = 4'b1010;
    shift_bits(16'h0A5C, 12);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cfg_sdo !== exp_sdo[3-i]) begin
        n_errors++; $display("FAIL sdo_shift%0d got %b exp %b", 13 + i, cfg_sdo, exp_sdo[3-i]);
      end
      shift_bits(16'h0000, 1);
    end
  endtask

  task automatic test_reset_configured;
    pulse_commit();
    n_checks++;
    if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL sat_overshift got %b exp 1", cfg_err); end
    cell_a = 4'hF;
    #1;
    n_checks++;
    if (cell_y !== 4'b0001) begin n_errors++; $display("FAIL pre_reset_y got %b exp 0001", cell_y); end
    cfg_sdi = 1'b1;
    cfg_shift_en = 1'b1;
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    n_checks++;
    if ({cell_y, cfg_sdo, cfg_err, cfg_done, lo} !== 8'b0) begin
      n_errors++; $display("FAIL async_reset_cfg got %b exp 0", {cell_y, cfg_sdo, cfg_err, cfg_done, lo});
    end
    cfg_shift_en = 1'b0;
    cfg_sdi = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_sequential();
    test_undershift();
    test_overshift_collision();
    test_chaining();
    test_reset_configured();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
